// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interface blocks: sequencer states,
// default acknowledge timing and the vector width.
package pic_pkg;

   localparam int VEC_W               = 8;
   localparam int INTA_LOW_CYCLES_DEF = 3;
   localparam int INTA_GAP_CYCLES_DEF = 2;
   localparam int HOLDOFF_CYCLES_DEF  = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACK1    = 3'd1,
      GAP     = 3'd2,
      ACK2    = 3'd3,
      DELIVER = 3'd4,
      HOLDOFF = 3'd5
   } inta_state_t;

   // Largest of three timing values; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/int_synchronizer.sv
// Multi-flop synchroniser for an asynchronous PIC pin. The output is the
// last flop of the chain; all flops clear on reset.
module int_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] sync_ff;

   // Shift the asynchronous pin through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_out = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge sequencer. Synchronises INT, issues the
// two-pulse INTA_n sequence under LOCK_n, captures the vector from the data
// bus at the end of the second pulse and hands it to the core via
// vector_valid / vector_ack. A hold-off period after delivery stops a stale
// synchronised INT from immediately re-triggering.
module inta_sequencer
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int INTA_LOW_CYCLES = INTA_LOW_CYCLES_DEF,
   parameter int INTA_GAP_CYCLES = INTA_GAP_CYCLES_DEF,
   parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             INT,
   input  logic             int_enable,
   input  logic [VEC_W-1:0] data_bus,
   output logic             INTA_n,
   output logic             LOCK_n,
   output logic [VEC_W-1:0] vector,
   output logic             vector_valid,
   input  logic             vector_ack,
   output logic             busy
);

   localparam logic [2:0] ST_IDLE    = IDLE;
   localparam logic [2:0] ST_ACK1    = ACK1;
   localparam logic [2:0] ST_GAP     = GAP;
   localparam logic [2:0] ST_ACK2    = ACK2;
   localparam logic [2:0] ST_DELIVER = DELIVER;
   localparam logic [2:0] ST_HOLDOFF = HOLDOFF;

   localparam int CNT_MAX = max3(INTA_LOW_CYCLES, INTA_GAP_CYCLES, HOLDOFF_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(INTA_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(INTA_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             int_sync;
   logic             cnt_zero;

   int_synchronizer #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (INT),
      .sync_out (int_sync)
   );

   assign cnt_zero = (cnt == '0);

   // Acknowledge FSM; every pin-facing output is registered so INTA_n and
   // LOCK_n change at most once per edge and release at once on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         INTA_n       <= 1'b1;
         LOCK_n       <= 1'b1;
         vector       <= '0;
         vector_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (int_sync && int_enable) begin
                  state  <= ST_ACK1;
                  cnt    <= LOW_LOAD;
                  INTA_n <= 1'b0;
                  LOCK_n <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            // Once the first pulse starts, both pulses always complete.
            ST_ACK1: begin
               if (cnt_zero) begin
                  state  <= ST_GAP;
                  cnt    <= GAP_LOAD;
                  INTA_n <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_zero) begin
                  state  <= ST_ACK2;
                  cnt    <= LOW_LOAD;
                  INTA_n <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // Vector is sampled in the last low cycle of the second pulse.
            ST_ACK2: begin
               if (cnt_zero) begin
                  state        <= ST_DELIVER;
                  vector       <= data_bus;
                  INTA_n       <= 1'b1;
                  LOCK_n       <= 1'b1;
                  vector_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DELIVER: begin
               if (vector_ack) begin
                  state        <= ST_HOLDOFF;
                  cnt          <= HOLD_LOAD;
                  vector_valid <= 1'b0;
               end
            end
            ST_HOLDOFF: begin
               if (cnt_zero) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state        <= ST_IDLE;
               cnt          <= '0;
               INTA_n       <= 1'b1;
               LOCK_n       <= 1'b1;
               vector_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: fixed edge-by-edge INTA_n/LOCK_n/busy
// schedule, plus a queue of expected vectors filled when data_bus is driven
// and drained when vector_valid is seen.
module tb_inta_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       INT;
   logic       int_enable;
   logic [7:0] data_bus;
   logic       INTA_n;
   logic       LOCK_n;
   logic [7:0] vector;
   logic       vector_valid;
   logic       vector_ack;
   logic       busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         falls = 0;
   logic       prev_inta = 1'b1;
   logic [7:0] sb[$];

   inta_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .INT          (INT),
      .int_enable   (int_enable),
      .data_bus     (data_bus),
      .INTA_n       (INTA_n),
      .LOCK_n       (LOCK_n),
      .vector       (vector),
      .vector_valid (vector_valid),
      .vector_ack   (vector_ack),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Count INTA_n falling transitions, sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (prev_inta === 1'b1 && INTA_n === 1'b0) falls++;
      prev_inta = INTA_n;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_inta(input int k);
      return !((k >= 3 && k <= 5) || (k >= 8 && k <= 10));
   endfunction

   function automatic logic exp_lock(input int k);
      return !(k >= 3 && k <= 10);
   endfunction

   task automatic pop_check(input string tag);
      if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
      else check(tag, {24'd0, vector}, {24'd0, sb.pop_front()});
   endtask

   // Walk edges first_k..last_k of a sequence whose INT was first sampled
   // at edge 1; INT is dropped after edge drop_k when drop_k > 0.
   task automatic run_seq(input int first_k, input int last_k, input int drop_k);
      for (int k = first_k; k <= last_k; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("inta_n_k%0d", k), {31'd0, INTA_n}, {31'd0, exp_inta(k)});
         check($sformatf("lock_n_k%0d", k), {31'd0, LOCK_n}, {31'd0, exp_lock(k)});
         check($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, (k >= 3)});
         if (k == 11) begin
            check("valid_k11", {31'd0, vector_valid}, 32'd1);
            pop_check("vector_k11");
         end
         if (k == drop_k) INT = 1'b0;
      end
   endtask

   task automatic ack_pulse();
      vector_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      vector_ack = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; INT = 1'b0; int_enable = 1'b0; data_bus = 8'h00; vector_ack = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_inta_n", {31'd0, INTA_n}, 32'd1);
      check("rst_lock_n", {31'd0, LOCK_n}, 32'd1);
      check("rst_vector", {24'd0, vector}, 32'd0);
      check("rst_valid", {31'd0, vector_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic sequence
      falls = 0;
      int_enable = 1'b1; data_bus = 8'h48; sb.push_back(8'h48); INT = 1'b1;
      run_seq(1, 11, 0);
      check("basic_falls", falls, 32'd2);

      // Handshake: hold off the ack, then pulse it
      INT = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(posedge clk); @(negedge clk);
         check("hs_valid_held", {31'd0, vector_valid}, 32'd1);
         check("hs_vector_held", {24'd0, vector}, 32'h48);
      end
      ack_pulse();
      check("hs_valid_drop", {31'd0, vector_valid}, 32'd0);
      check("hs_busy_ack", {31'd0, busy}, 32'd1);
      for (int j = 1; j <= 3; j++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("hs_busy_p%0d", j), {31'd0, busy}, {31'd0, (j < 3)});
      end
      repeat (5) @(negedge clk);

      // INT drops during GAP: the second pulse still completes
      falls = 0;
      data_bus = 8'hA5; sb.push_back(8'hA5); INT = 1'b1;
      run_seq(1, 11, 6);
      check("drop_falls", falls, 32'd2);
      ack_pulse();
      falls = 0;
      repeat (20) @(negedge clk);
      check("drop_no_third", falls, 32'd0);
      check("drop_inta_idle", {31'd0, INTA_n}, 32'd1);

      // Masked request
      int_enable = 1'b0; INT = 1'b1; data_bus = 8'h3C;
      for (int j = 0; j < 20; j++) begin
         @(posedge clk); @(negedge clk);
         check("mask_inta_n", {31'd0, INTA_n}, 32'd1);
         check("mask_busy", {31'd0, busy}, 32'd0);
      end
      falls = 0;
      int_enable = 1'b1; sb.push_back(8'h3C);
      run_seq(3, 11, 0);

      // Back-to-back with INT held high, acking immediately
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_falls_%0d", i), falls, 32'd2);
         falls = 0;
         data_bus = 8'h60 + 8'(i); sb.push_back(8'h60 + 8'(i));
         ack_pulse();
         check("b2b_valid_drop", {31'd0, vector_valid}, 32'd0);
         n = 0;
         while (INTA_n === 1'b1 && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (INTA_n === 1'b1) check("b2b_lock_idle", {31'd0, LOCK_n}, 32'd1);
         end
         check("b2b_restart_gap", n, 32'd4);
         n = 0;
         while (vector_valid !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
         end
         check("b2b_valid", {31'd0, vector_valid}, 32'd1);
         pop_check("b2b_vector");
      end
      check("b2b_falls_last", falls, 32'd2);
      INT = 1'b0;
      ack_pulse();
      repeat (10) @(negedge clk);

      // Asynchronous reset in the middle of ACK2
      data_bus = 8'hC3; INT = 1'b1;
      run_seq(1, 9, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_inta_n", {31'd0, INTA_n}, 32'd1);
      check("arst_lock_n", {31'd0, LOCK_n}, 32'd1);
      check("arst_valid", {31'd0, vector_valid}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_vector", {24'd0, vector}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      data_bus = 8'h5A; sb.push_back(8'h5A);
      run_seq(1, 11, 0);
      INT = 1'b0;
      ack_pulse();
      check("sb_leftover", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
